cond_ctrl_stage: RTL and testbench

- Producer side of the condition-unit interface in the pipelined ARM core.
- Registers Decode-stage control fields into the Execute stage and drives Cond, FlagW, PCS, RegW, MemW, Branch and FlagsE into the condition unit.
- Owns the architectural NZCV flags register, which is updated from the condition unit's ALUFlagsResult.
- Tracks in-flight PC writes and generates the taken-branch squash and the fetch-stall request.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/cond_ctrl_stage_if.sv | 61 ++++++
 rtl/cond_ctrl_stage_flopenrc.sv | 31 +++
 rtl/cond_ctrl_stage.sv | 80 ++++++++
 tb/tb_cond_ctrl_stage.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined ARM core.
// Holds the NZCV flag bit positions, the ARM condition codes and the bit
// positions inside the two-bit flag-write mask. The condition-unit producer
// stage and its bench import this package.
package cpu_pkg;

  localparam int FLAGS_W_DEF = 4;
  localparam int COND_W_DEF  = 4;

  // Bit positions inside the NZCV flags bus
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Bit positions inside the FlagW mask: [1] writes N/Z, [0] writes C/V
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110
  } cond_e;

endpackage

// File: rtl/cond_ctrl_stage_if.sv
// Bundle between the Decode/hazard logic, the Execute-stage control register
// and the condition unit.
//   master : the cond_ctrl_stage side (takes Decode fields, hazard controls,
//            PCSrc and ALUFlagsResult; drives the Execute fields, FlagsE,
//            FlushD, PCWrPending, PCSrcM and PCSrcW)
//   slave  : the surrounding pipeline / condition unit (mirror image)
interface cond_ctrl_stage_if
  import cpu_pkg::*;
#(
  parameter int FLAGS_W = FLAGS_W_DEF,
  parameter int COND_W  = COND_W_DEF
);

  // Decode-stage fields
  logic [COND_W-1:0]  CondD;
  logic [1:0]         FlagWD;
  logic               PCSD;
  logic               RegWD;
  logic               MemWD;
  logic               BranchD;
  logic               ValidD;

  // Hazard controls
  logic               StallE;
  logic               FlushE;

  // From the condition unit
  logic               PCSrc;
  logic [FLAGS_W-1:0] ALUFlagsResult;

  // Execute-stage fields towards the condition unit
  logic [COND_W-1:0]  CondE;
  logic [1:0]         FlagWE;
  logic               PCSE;
  logic               RegWE;
  logic               MemWE;
  logic               BranchE;
  logic               ValidE;
  logic [FLAGS_W-1:0] FlagsE;

  // Branch bookkeeping
  logic               FlushD;
  logic               PCWrPending;
  logic               PCSrcM;
  logic               PCSrcW;

  modport master (
    input  CondD, FlagWD, PCSD, RegWD, MemWD, BranchD, ValidD,
    input  StallE, FlushE, PCSrc, ALUFlagsResult,
    output CondE, FlagWE, PCSE, RegWE, MemWE, BranchE, ValidE, FlagsE,
    output FlushD, PCWrPending, PCSrcM, PCSrcW
  );

  modport slave (
    output CondD, FlagWD, PCSD, RegWD, MemWD, BranchD, ValidD,
    output StallE, FlushE, PCSrc, ALUFlagsResult,
    input  CondE, FlagWE, PCSE, RegWE, MemWE, BranchE, ValidE, FlagsE,
    input  FlushD, PCWrPending, PCSrcM, PCSrcW
  );

endinterface

// File: rtl/cond_ctrl_stage_flopenrc.sv
// flopenrc: register with an asynchronous active-low reset, a load enable
// and a synchronous clear.
//   clk   : clock
//   reset : asynchronous reset, active low (0 clears q)
//   en    : load enable; when low the register holds, even if clear is high
//   clear : synchronous clear, honoured only while en is high
//   d / q : data in / data out
module flopenrc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values present before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      // Clear sits under the enable so a stall always wins over a flush.
      if (clear) q <= '0;
      else       q <= d;
    end
  end

endmodule

// File: rtl/cond_ctrl_stage.sv
// cond_ctrl_stage: producer side of the condition-unit interface.
// Registers the Decode control fields into Execute, owns the architectural
// NZCV flags, tracks taken PC writes through Memory and Writeback, and
// produces the Decode squash and the fetch-stall request.
//   clk   : core clock
//   reset : asynchronous reset, active low
//   bus   : cond_ctrl_stage_if master modport (Decode fields, StallE,
//           FlushE, PCSrc, ALUFlagsResult in; Execute fields, FlagsE,
//           FlushD, PCWrPending, PCSrcM, PCSrcW out)
module cond_ctrl_stage
  import cpu_pkg::*;
#(
  parameter int FLAGS_W = FLAGS_W_DEF,
  parameter int COND_W  = COND_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  cond_ctrl_stage_if.master    bus
);

  // Execute control word: {cond, flagw[1:0], pcs, regw, memw, branch, valid}
  localparam int CTRL_W = COND_W + 7;

  logic              squash_e;
  logic [CTRL_W-1:0] ctrl_d;
  logic [CTRL_W-1:0] ctrl_q;

  // A taken PC write only counts when Execute holds a real instruction.
  assign squash_e = bus.ValidE & bus.PCSrc;

  // An empty Decode slot enters Execute as an all-zero word, so a stray
  // control bit can never write state downstream.
  assign ctrl_d = bus.ValidD
                ? {bus.CondD, bus.FlagWD, bus.PCSD, bus.RegWD, bus.MemWD,
                   bus.BranchD, 1'b1}
                : '0;

  flopenrc #(.WIDTH(CTRL_W)) u_ctrl_e (
    .clk   (clk),
    .reset (reset),
    .en    (~bus.StallE),
    .clear (bus.FlushE | squash_e),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  assign {bus.CondE, bus.FlagWE, bus.PCSE, bus.RegWE, bus.MemWE,
          bus.BranchE, bus.ValidE} = ctrl_q;

  // Flags follow the instruction: only a real, advancing Execute
  // instruction commits the merged flags from the condition unit.
  flopenrc #(.WIDTH(FLAGS_W)) u_flags (
    .clk   (clk),
    .reset (reset),
    .en    (bus.ValidE & ~bus.StallE),
    .clear (1'b0),
    .d     (bus.ALUFlagsResult),
    .q     (bus.FlagsE)
  );

  // A stalled Execute does not advance, so Memory receives a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.PCSrcM <= 1'b0;
      bus.PCSrcW <= 1'b0;
    end else begin
      bus.PCSrcM <= squash_e & ~bus.StallE;
      bus.PCSrcW <= bus.PCSrcM;
    end
  end

  assign bus.FlushD = squash_e;

  // Fetch stays stalled from the moment a PC-writing instruction is seen in
  // Decode until its taken write has reached Writeback.
  assign bus.PCWrPending = (bus.PCSD & bus.ValidD)
                         | (bus.PCSE & bus.ValidE)
                         | bus.PCSrcM;

endmodule

// File: tb/tb_cond_ctrl_stage.sv
// Directed bench for cond_ctrl_stage: reset, flag commit, taken branch,
// stall-over-flush, flush bubble, PC-write tracking and async reset.
module tb_cond_ctrl_stage;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  cond_ctrl_stage_if #(.FLAGS_W(4), .COND_W(4)) cif ();

  cond_ctrl_stage #(.FLAGS_W(4), .COND_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    cif.CondD   = 4'h0;
    cif.FlagWD  = 2'b00;
    cif.PCSD    = 1'b0;
    cif.RegWD   = 1'b0;
    cif.MemWD   = 1'b0;
    cif.BranchD = 1'b0;
    cif.ValidD  = 1'b0;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b0;
    clear_d();
    cif.StallE         = 1'b0;
    cif.FlushE         = 1'b0;
    cif.PCSrc          = 1'b0;
    cif.ALUFlagsResult = 4'h0;

    // ---- Reset held with random Decode traffic ----
    for (int i = 0; i < 4; i++) begin
      cif.CondD   = 4'($urandom);
      cif.FlagWD  = 2'($urandom);
      cif.RegWD   = 1'($urandom);
      cif.MemWD   = 1'($urandom);
      cif.BranchD = 1'($urandom);
      cif.ValidD  = 1'b1;
      cif.ALUFlagsResult = 4'($urandom);
      tick();
    end
    check("rst_valide", 32'(cif.ValidE), 0);
    check("rst_conde",  32'(cif.CondE),  0);
    check("rst_regwe",  32'(cif.RegWE),  0);
    check("rst_memwe",  32'(cif.MemWE),  0);
    check("rst_flags",  32'(cif.FlagsE), 0);
    check("rst_pcsrcm", 32'(cif.PCSrcM), 0);
    check("rst_pcsrcw", 32'(cif.PCSrcW), 0);

    // ---- Release: first edge loads normally ----
    reset = 1'b1;
    clear_d();
    cif.CondD  = COND_AL;
    cif.RegWD  = 1'b1;
    cif.ValidD = 1'b1;
    cif.ALUFlagsResult = 4'h0;
    tick();
    check("rel_valide", 32'(cif.ValidE), 1);
    check("rel_conde",  32'(cif.CondE),  32'hE);
    check("rel_regwe",  32'(cif.RegWE),  1);
    check("rel_memwe",  32'(cif.MemWE),  0);

    // ---- Flag update, then a bubble must not touch the flags ----
    clear_d();
    cif.ALUFlagsResult = 4'b0110;
    tick();
    check("flag_load",   32'(cif.FlagsE), 32'b0110);
    check("flag_bubble", 32'(cif.ValidE), 0);
    cif.ALUFlagsResult = 4'b1001;
    tick();
    check("flag_hold",   32'(cif.FlagsE), 32'b0110);

    // ---- Taken branch ----
    cif.ALUFlagsResult = 4'b0110;
    cif.BranchD = 1'b1;
    cif.ValidD  = 1'b1;
    tick();
    check("br_branche", 32'(cif.BranchE), 1);
    clear_d();
    cif.RegWD  = 1'b1;
    cif.ValidD = 1'b1;
    cif.PCSrc  = 1'b1;
    #1;
    check("br_flushd",  32'(cif.FlushD), 1);
    tick();
    check("br_squash",  32'(cif.ValidE), 0);
    check("br_pcsrcm",  32'(cif.PCSrcM), 1);
    check("br_flushd0", 32'(cif.FlushD), 0);
    cif.PCSrc = 1'b0;
    clear_d();
    tick();
    check("br_pcsrcw",  32'(cif.PCSrcW), 1);
    check("br_pcsrcm0", 32'(cif.PCSrcM), 0);

    // ---- PCSrc ignored while Execute is empty ----
    cif.PCSrc = 1'b1;
    #1;
    check("idle_flushd", 32'(cif.FlushD), 0);
    tick();
    check("idle_pcsrcm", 32'(cif.PCSrcM), 0);
    cif.PCSrc = 1'b0;

    // ---- Stall beats flush ----
    cif.CondD  = COND_NE;
    cif.MemWD  = 1'b1;
    cif.ValidD = 1'b1;
    tick();
    check("sf_memwe_ld", 32'(cif.MemWE), 1);
    clear_d();
    cif.CondD  = COND_GT;
    cif.RegWD  = 1'b1;
    cif.ValidD = 1'b1;
    cif.StallE = 1'b1;
    cif.FlushE = 1'b1;
    cif.PCSrc  = 1'b1;
    cif.ALUFlagsResult = 4'b1111;
    tick();
    check("sf_memwe",  32'(cif.MemWE),  1);
    check("sf_conde",  32'(cif.CondE),  32'h1);
    check("sf_valide", 32'(cif.ValidE), 1);
    check("sf_regwe",  32'(cif.RegWE),  0);
    check("sf_flags",  32'(cif.FlagsE), 32'b0110);
    check("sf_pcsrcm", 32'(cif.PCSrcM), 0);
    cif.StallE = 1'b0;
    cif.FlushE = 1'b0;
    cif.PCSrc  = 1'b0;
    clear_d();
    tick();
    check("sf_flags_go", 32'(cif.FlagsE), 32'b1111);

    // ---- FlushE alone inserts a bubble ----
    cif.ALUFlagsResult = 4'b0000;
    cif.RegWD  = 1'b1;
    cif.ValidD = 1'b1;
    cif.FlushE = 1'b1;
    tick();
    check("fl_valide", 32'(cif.ValidE), 0);
    check("fl_regwe",  32'(cif.RegWE),  0);
    cif.FlushE = 1'b0;
    clear_d();
    tick();

    // ---- PCWrPending with a taken PC write ----
    cif.PCSD   = 1'b1;
    cif.ValidD = 1'b1;
    #1;
    check("pend_d", 32'(cif.PCWrPending), 1);
    tick();
    clear_d();
    #1;
    check("pend_e", 32'(cif.PCWrPending), 1);
    cif.PCSrc = 1'b1;
    tick();
    cif.PCSrc = 1'b0;
    check("pend_m", 32'(cif.PCWrPending), 1);
    tick();
    check("pend_w_pcsrcw", 32'(cif.PCSrcW), 1);
    check("pend_w",        32'(cif.PCWrPending), 0);

    // ---- PCWrPending with a failed condition ----
    cif.PCSD   = 1'b1;
    cif.ValidD = 1'b1;
    tick();
    clear_d();
    #1;
    check("nt_pend_e", 32'(cif.PCWrPending), 1);
    tick();
    check("nt_pend_m", 32'(cif.PCWrPending), 0);

    // ---- Async reset while a taken branch sits in Memory ----
    cif.ALUFlagsResult = 4'b1010;
    cif.BranchD = 1'b1;
    cif.ValidD  = 1'b1;
    tick();
    check("ar_flags_pre", 32'(cif.FlagsE), 0);
    clear_d();
    cif.CondD  = COND_AL;
    cif.ValidD = 1'b1;
    cif.PCSrc  = 1'b1;
    tick();
    cif.PCSrc = 1'b0;
    check("ar_pcsrcm_pre", 32'(cif.PCSrcM), 1);
    check("ar_flags_set",  32'(cif.FlagsE), 32'b1010);
    #3;
    reset = 1'b0;
    #1;
    check("ar_pcsrcm", 32'(cif.PCSrcM), 0);
    check("ar_pcsrcw", 32'(cif.PCSrcW), 0);
    check("ar_valide", 32'(cif.ValidE), 0);
    check("ar_flags",  32'(cif.FlagsE), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("ar_reload_v", 32'(cif.ValidE), 1);
    check("ar_reload_c", 32'(cif.CondE),  32'hE);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
